crc_tx_sequencer: RTL and testbench

Controller that sequences the team's serial CAN CRC-15 engine (polynomial 0x4599, MSB-first, register cleared to 0) for one frame at a time. It clears the engine, streams a latched frame of `len` bits into it one bit per clock, captures the 15-bit checksum, then serialises it MSB-first to the bit-stuffing/TX stage over a valid/ready handshake. It sits between the frame assembler and the TX bitstream path; the CRC engine is external and driven only by this block.

---
 rtl/crc_tx_sequencer.sv | 118 +++++++++++
 tb/tb_crc_tx_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/crc_tx_sequencer.sv
// Sequences an external serial CAN CRC-15 engine over one latched frame, then
// serialises the captured checksum MSB-first over a valid/ready handshake.
module crc_tx_sequencer #(
  parameter int MAX_LEN = 96,
  parameter int LEN_W   = 7,
  parameter int CRC_W   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] frame,
  input  logic [LEN_W-1:0]   len,
  input  logic               abort,
  output logic               crc_clr,
  output logic               crc_en,
  output logic               crc_din,
  input  logic [CRC_W-1:0]   crc_val,
  output logic               tx_bit,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [CRC_W-1:0]   crc_out,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = $clog2(CRC_W);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, CAPTURE, SHIFT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] frame_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CRC_W-1:0]   crc_reg;
  logic [LEN_W-1:0]   len_clamped;
  logic [LEN_W-1:0]   cnt_minus;
  logic               accept;

  assign len_clamped = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  assign cnt_minus   = cnt_reg - 1'b1;
  assign accept      = (state_reg == IDLE) && start && !abort;
  assign crc_out     = crc_reg;
  assign busy        = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      frame_reg <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      crc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      if (accept) begin
        frame_reg <= frame;
        len_reg   <= len_clamped;
      end
      // An abort landing on the capture cycle leaves the previous checksum intact.
      if (state_reg == CAPTURE && !abort)
        crc_reg <= crc_val;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_din    = 1'b0;
    tx_bit     = 1'b0;
    tx_valid   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = CLEAR;
      end
      CLEAR: begin
        crc_clr = 1'b1;
        if (len_reg == '0) begin
          state_next = CAPTURE;
        end else begin
          cnt_next   = len_reg;
          state_next = FEED;
        end
      end
      FEED: begin
        crc_en   = 1'b1;
        crc_din  = frame_reg[cnt_minus];
        cnt_next = cnt_minus;
        if (cnt_reg == LEN_W'(1)) state_next = CAPTURE;
      end
      CAPTURE: begin
        idx_next   = IDX_W'(CRC_W - 1);
        state_next = SHIFT;
      end
      SHIFT: begin
        tx_valid = 1'b1;
        tx_bit   = crc_reg[idx_reg];
        if (tx_ready) begin
          if (idx_reg == '0) state_next = DONE;
          else               idx_next   = idx_reg - 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && state_reg != IDLE) state_next = IDLE;
  end

endmodule

// File: tb/tb_crc_tx_sequencer.sv
// Bench for crc_tx_sequencer: emulates the external CRC engine and checks each
// frame against a polynomial long-division reference.
module tb_crc_tx_sequencer;
  localparam int MAX_LEN = 96;
  localparam int LEN_W   = 7;
  localparam int CRC_W   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [MAX_LEN-1:0] frame = '0;
  logic [LEN_W-1:0] len = '0;
  logic abort = 1'b0;
  logic crc_clr, crc_en, crc_din;
  logic [CRC_W-1:0] crc_val = '0;
  logic tx_bit, tx_valid;
  logic tx_ready = 1'b1;
  logic [CRC_W-1:0] crc_out;
  logic busy, done;

  int checks = 0;
  int errors = 0;

  crc_tx_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CRC_W(CRC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .frame(frame), .len(len), .abort(abort),
    .crc_clr(crc_clr), .crc_en(crc_en), .crc_din(crc_din), .crc_val(crc_val),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .crc_out(crc_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External serial CRC-15 engine (LFSR form), cleared by crc_clr.
  always @(posedge clk) begin
    if (crc_clr) crc_val <= '0;
    else if (crc_en)
      crc_val <= {crc_val[13:0], 1'b0} ^ ((crc_din ^ crc_val[14]) ? 15'h4599 : 15'h0000);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of M(x)*x^15 divided by x^15 + 0x4599, message MSB (frame[n-1]) first.
  function automatic logic [14:0] ref_crc(input logic [MAX_LEN-1:0] f, input int n);
    bit m[$];
    logic [15:0] g = 16'hC599;
    logic [14:0] r;
    for (int i = n - 1; i >= 0; i--) m.push_back(f[i]);
    repeat (15) m.push_back(1'b0);
    for (int i = 0; i + 15 < m.size(); i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
    for (int j = 0; j < 15; j++) r[14-j] = m[m.size() - 15 + j];
    return r;
  endfunction

  task automatic pulse_start(input int l, input logic [MAX_LEN-1:0] f);
    @(negedge clk);
    start = 1'b1; frame = f; len = LEN_W'(l);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: ready always 1, 1: toggling, 2: random. glitch pulses start mid-frame.
  task automatic run_frame(input string tag, input int l, input logic [MAX_LEN-1:0] f,
                           input int mode, input bit glitch);
    int n, c, hs, done_cyc, last_hs, clr_cnt, en_cnt;
    bit busy_ok, pv, pr, pb;
    logic [14:0] exp_crc, tx_seq;
    logic [MAX_LEN-1:0] din_seq, mask;
    n = (l > MAX_LEN) ? MAX_LEN : l;
    exp_crc = ref_crc(f, n);
    mask = '0;
    for (int i = 0; i < n; i++) mask[i] = 1'b1;
    hs = 0; done_cyc = -1; last_hs = -1; clr_cnt = 0; en_cnt = 0;
    busy_ok = 1; pv = 0; pr = 0; pb = 0; tx_seq = '0; din_seq = '0;
    pulse_start(l, f);
    for (c = 1; c < 300; c++) begin
      if (c > 1) @(posedge clk);
      #1;
      start = 1'b0;
      if (glitch && c == 3) begin
        start = 1'b1; frame = ~f; len = LEN_W'(5);
      end
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = c[0];
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (!busy) busy_ok = 0;
      if (crc_clr) clr_cnt++;
      if (crc_en) begin en_cnt++; din_seq = {din_seq[MAX_LEN-2:0], crc_din}; end
      if (pv && !pr) begin
        chk({tag, " hold_valid"}, tx_valid, 1'b1);
        chk({tag, " hold_bit"}, tx_bit, pb);
      end
      if (tx_valid && tx_ready) begin
        tx_seq = {tx_seq[13:0], tx_bit}; hs++; last_hs = c;
      end
      pv = tx_valid; pr = tx_ready; pb = tx_bit;
      if (done) begin done_cyc = c; break; end
    end
    start = 1'b0;
    chk({tag, " done_seen"}, (done_cyc > 0), 1'b1);
    chk({tag, " crc_out"}, crc_out, exp_crc);
    chk({tag, " tx_bits"}, tx_seq, exp_crc);
    chk({tag, " handshakes"}, hs, 15);
    chk({tag, " clr_pulses"}, clr_cnt, 1);
    chk({tag, " en_cycles"}, en_cnt, n);
    chk({tag, " din_seq"}, din_seq, f & mask);
    chk({tag, " busy_held"}, busy_ok, 1'b1);
    chk({tag, " done_after_last_hs"}, done_cyc, last_hs + 1);
    if (mode == 0) chk({tag, " done_latency"}, done_cyc, n + 18);
    @(posedge clk); #2;
    chk({tag, " busy_after"}, busy, 1'b0);
    chk({tag, " done_pulse"}, done, 1'b0);
    $display("frame %s len=%0d mode=%0d crc=%04h done_cycle=%0d", tag, l, mode, crc_out, done_cyc);
  endtask

  task automatic run_abort(input int l, input logic [MAX_LEN-1:0] f);
    logic [14:0] prev;
    bit quiet;
    prev = crc_out;
    quiet = 1;
    pulse_start(l, f);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort crc_en", crc_en, 1'b0);
    repeat (25) begin
      @(posedge clk); #2;
      if (tx_valid || done || busy) quiet = 0;
    end
    chk("abort quiet", quiet, 1'b1);
    chk("abort crc_out", crc_out, prev);
    $display("abort len=%0d crc_out=%04h", l, crc_out);
  endtask

  initial begin
    logic [MAX_LEN-1:0] rf;
    int rl;
    repeat (3) @(posedge clk);
    #2;
    chk("reset busy", busy, 1'b0);
    chk("reset tx_valid", tx_valid, 1'b0);
    chk("reset crc_out", crc_out, 15'h0);
    chk("reset ctrl", {crc_clr, crc_en, crc_din, tx_bit, done}, 5'b0);
    @(negedge clk) rst = 1'b0;

    run_frame("len1", 1, 96'h1, 0, 0);
    run_frame("len2", 2, 96'h2, 0, 0);
    run_frame("len0", 0, 96'h0, 0, 0);
    run_frame("len120", 120, {$urandom, $urandom, $urandom}, 0, 0);
    run_frame("toggle", 2, 96'h2, 1, 0);
    run_frame("glitch", 20, {$urandom, $urandom, $urandom}, 0, 1);
    run_abort(30, {$urandom, $urandom, $urandom});
    run_frame("post_abort", 1, 96'h1, 0, 0);

    // abort and start together in IDLE: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1; len = 7'd4;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0; #1;
    chk("abort_start busy", busy, 1'b0);

    for (int k = 0; k < 8; k++) begin
      rf = {$urandom, $urandom, $urandom};
      rl = $urandom_range(0, 127);
      run_frame($sformatf("rand%0d", k), rl, rf, $urandom_range(0, 2), 0);
    end

    // asynchronous reset mid-SHIFT
    pulse_start(10, {$urandom, $urandom, $urandom});
    repeat (16) @(posedge clk);
    #1;
    chk("pre_rst tx_valid", tx_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst tx_valid", tx_valid, 1'b0);
    chk("async_rst busy", busy, 1'b0);
    chk("async_rst crc_out", crc_out, 15'h0);
    $display("async reset mid-shift tx_valid=%0b busy=%0b crc_out=%04h", tx_valid, busy, crc_out);
    @(negedge clk) rst = 1'b0;
    run_frame("post_rst", 2, 96'h2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
